// File: rtl/rom_read_arbiter.sv
// Two-master round-robin read arbiter and burst sequencer for the ROM bus slave port.
// The ROM slave never flags the final beat, so beat counting and RLAST generation live here.
`ifndef BUS_ADDR_BITS
`define BUS_ADDR_BITS 16
`endif
`ifndef BUS_DATA_BITS
`define BUS_DATA_BITS 32
`endif
`ifndef BUS_LEN_BITS
`define BUS_LEN_BITS 8
`endif

module rom_read_arbiter #(
   parameter int unsigned ADDR_W = `BUS_ADDR_BITS,
   parameter int unsigned DATA_W = `BUS_DATA_BITS,
   parameter int unsigned LEN_W  = `BUS_LEN_BITS
) (
   input  logic              bus_clk,
   input  logic              bus_rst,
   input  logic              REQ_M0,
   input  logic [ADDR_W-1:0] ADDR_M0,
   input  logic [LEN_W-1:0]  BLEN_M0,
   output logic              GNT_M0,
   output logic [DATA_W-1:0] RDATA_M0,
   output logic              RVALID_M0,
   output logic              RLAST_M0,
   input  logic              REQ_M1,
   input  logic [ADDR_W-1:0] ADDR_M1,
   input  logic [LEN_W-1:0]  BLEN_M1,
   output logic              GNT_M1,
   output logic [DATA_W-1:0] RDATA_M1,
   output logic              RVALID_M1,
   output logic              RLAST_M1,
   output logic [ADDR_W-1:0] ADDR_S,
   output logic [LEN_W-1:0]  BLEN_S,
   output logic              RVALID_S,
   input  logic [DATA_W-1:0] RDATA_S,
   input  logic              RREADY_S,
   output logic              BUSY
);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e             state_q;
   logic               last_owner_q;
   logic               owner_q;
   logic [ADDR_W-1:0]  cur_addr_q;
   logic [LEN_W-1:0]   remaining_q;

   logic               win_m1;
   logic [LEN_W-1:0]   blen_sel;
   logic               last_beat;

   // On contention the master that did not own the previous burst wins.
   always_comb begin
      win_m1   = REQ_M1 & (~REQ_M0 | ~last_owner_q);
      blen_sel = win_m1 ? BLEN_M1 : BLEN_M0;
      if (blen_sel == '0) begin
         blen_sel = LEN_W'(1);
      end
      last_beat = (remaining_q == LEN_W'(1));
   end

   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         state_q      <= StIdle;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         GNT_M0       <= 1'b0;
         GNT_M1       <= 1'b0;
         RVALID_M0    <= 1'b0;
         RVALID_M1    <= 1'b0;
         RLAST_M0     <= 1'b0;
         RLAST_M1     <= 1'b0;
         RDATA_M0     <= '0;
         RDATA_M1     <= '0;
      end else begin
         GNT_M0    <= 1'b0;
         GNT_M1    <= 1'b0;
         RVALID_M0 <= 1'b0;
         RVALID_M1 <= 1'b0;
         RLAST_M0  <= 1'b0;
         RLAST_M1  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (REQ_M0 | REQ_M1) begin
                  owner_q      <= win_m1;
                  last_owner_q <= win_m1;
                  cur_addr_q   <= win_m1 ? ADDR_M1 : ADDR_M0;
                  remaining_q  <= blen_sel;
                  GNT_M0       <= ~win_m1;
                  GNT_M1       <= win_m1;
                  state_q      <= StBurst;
               end
            end
            StBurst: begin
               // A stalled beat leaves every register untouched.
               if (RREADY_S) begin
                  cur_addr_q  <= cur_addr_q + ADDR_W'(1);
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (owner_q) begin
                     RDATA_M1  <= RDATA_S;
                     RVALID_M1 <= 1'b1;
                     RLAST_M1  <= last_beat;
                  end else begin
                     RDATA_M0  <= RDATA_S;
                     RVALID_M0 <= 1'b1;
                     RLAST_M0  <= last_beat;
                  end
                  if (last_beat) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign BUSY     = (state_q == StBurst);
   assign RVALID_S = BUSY;
   assign ADDR_S   = BUSY ? cur_addr_q : '0;
   assign BLEN_S   = BUSY ? remaining_q : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: table-driven single bursts plus hand-written
// contention, backpressure and mid-burst reset sequences against a modelled ROM.
module tb_rom_read_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;
   localparam int unsigned LW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [LW-1:0] blen0 = '0, blen1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1;
   logic [DW-1:0] rdata0, rdata1, rdata_s;
   logic [AW-1:0] addr_s;
   logic [LW-1:0] blen_s;
   logic          rvalid_s, busy;
   logic          rready = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          m;
      logic [AW-1:0] addr;
      logic [LW-1:0] blen;
      int            beats;
      logic [AW-1:0] last_addr;
   } vec_t;

   vec_t vecs[5];

   int   ng, nv0, nv1, nidle;
   int   gcyc[4];
   logic gown[4];
   logic overlap;
   int   exp_gcyc[4] = '{1, 4, 7, 10};
   logic exp_gown[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   rom_read_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .LEN_W (LW)
   ) dut (
      .bus_clk  (clk),
      .bus_rst  (rst),
      .REQ_M0   (req0),
      .ADDR_M0  (addr0),
      .BLEN_M0  (blen0),
      .GNT_M0   (gnt0),
      .RDATA_M0 (rdata0),
      .RVALID_M0(rvalid0),
      .RLAST_M0 (rlast0),
      .REQ_M1   (req1),
      .ADDR_M1  (addr1),
      .BLEN_M1  (blen1),
      .GNT_M1   (gnt1),
      .RDATA_M1 (rdata1),
      .RVALID_M1(rvalid1),
      .RLAST_M1 (rlast1),
      .ADDR_S   (addr_s),
      .BLEN_S   (blen_s),
      .RVALID_S (rvalid_s),
      .RDATA_S  (rdata_s),
      .RREADY_S (rready),
      .BUSY     (busy)
   );

   function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
      return {a ^ 8'h5A, ~a};
   endfunction

   assign rdata_s = rom(addr_s);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, {24'd0, gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, rvalid_s, busy}, 0);
      chk({tag, "_rdata0"}, rdata0, 0);
      chk({tag, "_rdata1"}, rdata1, 0);
      chk({tag, "_addr_s"}, addr_s, 0);
      chk({tag, "_blen_s"}, blen_s, 0);
   endtask

   task automatic run_burst(input vec_t v);
      logic [AW-1:0] ea;
      if (v.m) begin
         req1 = 1'b1; addr1 = v.addr; blen1 = v.blen;
      end else begin
         req0 = 1'b1; addr0 = v.addr; blen0 = v.blen;
      end
      tick();
      chk("gnt_owner", v.m ? gnt1 : gnt0, 1);
      chk("gnt_other", v.m ? gnt0 : gnt1, 0);
      chk("busy_start", busy, 1);
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < v.beats; i++) begin
         ea = v.addr + AW'(i);
         chk("addr_s", addr_s, ea);
         chk("blen_s", blen_s, v.beats - i);
         chk("rvalid_s", rvalid_s, 1);
         if (i > 0) begin
            chk("rvalid_m", v.m ? rvalid1 : rvalid0, 1);
            chk("rdata_m", v.m ? rdata1 : rdata0, rom(ea - 8'd1));
            chk("rlast_early", v.m ? rlast1 : rlast0, 0);
            chk("gnt_pulse", gnt0 | gnt1, 0);
         end else begin
            chk("rvalid_m_first", v.m ? rvalid1 : rvalid0, 0);
         end
         if (i == v.beats - 1) chk("last_addr", addr_s, v.last_addr);
         tick();
      end
      chk("rvalid_m_last", v.m ? rvalid1 : rvalid0, 1);
      chk("rdata_m_last", v.m ? rdata1 : rdata0, rom(v.last_addr));
      chk("rlast_m", v.m ? rlast1 : rlast0, 1);
      chk("rvalid_other", v.m ? rvalid0 : rvalid1, 0);
      chk("busy_end", busy, 0);
      tick();
      chk("rvalid_m_after", v.m ? rvalid1 : rvalid0, 0);
      chk("rlast_m_after", v.m ? rlast1 : rlast0, 0);
   endtask

   initial begin
      vecs[0] = '{m: 1'b0, addr: 8'h10, blen: 4'd4,  beats: 4,  last_addr: 8'h13};
      vecs[1] = '{m: 1'b1, addr: 8'hFF, blen: 4'd0,  beats: 1,  last_addr: 8'hFF};
      vecs[2] = '{m: 1'b0, addr: 8'hFE, blen: 4'd3,  beats: 3,  last_addr: 8'h00};
      vecs[3] = '{m: 1'b1, addr: 8'h40, blen: 4'd1,  beats: 1,  last_addr: 8'h40};
      vecs[4] = '{m: 1'b0, addr: 8'h20, blen: 4'd15, beats: 15, last_addr: 8'h2E};

      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      foreach (vecs[k]) run_burst(vecs[k]);

      // Contention: both masters hold 2-beat requests from a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0 = 1'b1; addr0 = 8'h30; blen0 = 4'd2;
      req1 = 1'b1; addr1 = 8'h80; blen1 = 4'd2;
      ng = 0; nv0 = 0; nv1 = 0; nidle = 0; overlap = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         if (gnt0 | gnt1) begin
            if (ng < 4) begin
               gcyc[ng] = cyc;
               gown[ng] = gnt1;
            end
            ng++;
         end
         if (rvalid0 & rvalid1) overlap = 1'b1;
         nv0 += int'(rvalid0);
         nv1 += int'(rvalid1);
         if (!busy) nidle++;
         if (cyc == 12) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      chk("cont_grants", ng, 4);
      for (int g = 0; g < 4; g++) begin
         chk("cont_gnt_cycle", gcyc[g], exp_gcyc[g]);
         chk("cont_gnt_owner", gown[g], exp_gown[g]);
      end
      chk("cont_overlap", overlap, 0);
      chk("cont_beats_m0", nv0, 4);
      chk("cont_beats_m1", nv1, 4);
      chk("cont_idle_cycles", nidle, 4);
      tick();

      // Backpressure: 4-beat M0 burst stalled for 3 cycles after beat 2.
      req0 = 1'b1; addr0 = 8'h50; blen0 = 4'd4;
      tick();
      req0 = 1'b0;
      chk("bp_gnt", gnt0, 1);
      chk("bp_addr0", addr_s, 8'h50);
      tick();
      chk("bp_addr1", addr_s, 8'h51);
      chk("bp_data0", rdata0, rom(8'h50));
      tick();
      chk("bp_addr2", addr_s, 8'h52);
      chk("bp_data1", rdata0, rom(8'h51));
      rready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("bp_stall_addr", addr_s, 8'h52);
         chk("bp_stall_blen", blen_s, 2);
         chk("bp_stall_rvalid", rvalid0, 0);
         chk("bp_stall_rdata", rdata0, rom(8'h51));
         chk("bp_stall_busy", busy, 1);
      end
      rready = 1'b1;
      tick();
      chk("bp_addr3", addr_s, 8'h53);
      chk("bp_blen3", blen_s, 1);
      chk("bp_data2", rdata0, rom(8'h52));
      chk("bp_rlast2", rlast0, 0);
      tick();
      chk("bp_data3", rdata0, rom(8'h53));
      chk("bp_rlast3", rlast0, 1);
      chk("bp_busy_end", busy, 0);
      tick();

      // Reset during beat 3 of a 5-beat M1 burst.
      req1 = 1'b1; addr1 = 8'h60; blen1 = 4'd5;
      tick();
      req1 = 1'b0;
      chk("rst_gnt1", gnt1, 1);
      tick();
      tick();
      chk("rst_beat3_addr", addr_s, 8'h62);
      rst = 1'b1;
      tick();
      chk_all_zero("midrst");
      rst = 1'b0;
      req0 = 1'b1; addr0 = 8'h70; blen0 = 4'd1;
      req1 = 1'b1; addr1 = 8'h90; blen1 = 4'd1;
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      chk("post_rst_gnt0", gnt0, 1);
      chk("post_rst_gnt1", gnt1, 0);
      chk("post_rst_addr", addr_s, 8'h70);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
